// File: rtl/prog_loader_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_ctrl_pkg
//  Purpose  : Shared types and constants for the program loader.
//  Revision : 1.0  initial release
// ============================================================================
package prog_loader_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } loader_state_t;

   localparam int BYTES_PER_WORD   = 4;
   localparam int LOADER_LEN_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/prog_loader_ctrl_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : byte_word_assembler
//  Purpose  : Packs a big-endian byte stream into 32-bit words.
//  Revision : 1.0  initial release
// ============================================================================
module byte_word_assembler
   import prog_loader_ctrl_pkg::*;
(
   input  logic        CLK,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_out,
   output logic        word_ready
);

   localparam logic [1:0] c_last = 2'(BYTES_PER_WORD - 1);

   logic [23:0] r_shift;
   logic [1:0]  r_count;

   // The completing byte is appended combinationally so the owner can
   // register the full word on the same edge that consumes it.
   assign word_out   = {r_shift, byte_in};
   assign word_ready = byte_valid && (r_count == c_last);

   always_ff @(posedge CLK) begin
      if (reset || clear) begin
         r_shift <= 24'd0;
         r_count <= 2'd0;
      end else if (byte_valid) begin
         r_shift <= {r_shift[15:0], byte_in};
         r_count <= r_count + 2'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader_ctrl
//  Purpose  : Loads a length-prefixed program byte stream into instruction RAM.
//  Revision : 1.0  initial release
// ============================================================================
module prog_loader_ctrl
   import prog_loader_ctrl_pkg::*;
#(
   parameter int INST_MEM_WIDTH = 10
)(
   input  logic                      CLK,
   input  logic                      reset,
   input  logic [7:0]                input_data,
   input  logic                      input_valid,
   input  logic                      input_start,
   output logic                      mem_we,
   output logic [INST_MEM_WIDTH-1:0] mem_addr,
   output logic [31:0]               mem_wdata,
   output logic                      inst_enable,
   output logic                      load_busy,
   output logic                      load_error
);

   localparam logic [32:0] c_depth = 33'd1 << INST_MEM_WIDTH;

   loader_state_t             r_state;
   logic [INST_MEM_WIDTH:0]   r_word_idx;
   logic [INST_MEM_WIDTH:0]   r_len_words;
   logic                      r_mem_we;
   logic [INST_MEM_WIDTH-1:0] r_mem_addr;
   logic [31:0]               r_mem_wdata;
   logic                      r_inst_enable;

   logic                      w_accept;
   logic [31:0]               w_word;
   logic                      w_word_ready;
   logic [INST_MEM_WIDTH:0]   w_next_idx;

   // A start strobe always wins over a coincident byte.
   assign w_accept   = input_valid && !input_start &&
                       ((r_state == LEN) || (r_state == DATA));
   assign w_next_idx = r_word_idx + 1'b1;

   byte_word_assembler u_asm (
      .CLK        (CLK),
      .reset      (reset),
      .clear      (input_start),
      .byte_valid (w_accept),
      .byte_in    (input_data),
      .word_out   (w_word),
      .word_ready (w_word_ready)
   );

   always_ff @(posedge CLK) begin
      if (reset) begin
         r_state       <= IDLE;
         r_word_idx    <= '0;
         r_len_words   <= '0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= 32'd0;
         r_inst_enable <= 1'b0;
      end else begin
         r_mem_we      <= 1'b0;
         // Enable trails DONE by one cycle so the last write lands first.
         r_inst_enable <= (r_state == DONE);
         if (input_start) begin
            r_state       <= LEN;
            r_word_idx    <= '0;
            r_len_words   <= '0;
            r_inst_enable <= 1'b0;
         end else begin
            case (r_state)
               LEN: begin
                  if (w_word_ready) begin
                     r_len_words <= w_word[INST_MEM_WIDTH:0];
                     if (w_word == 32'd0)
                        r_state <= DONE;
                     else if ({1'b0, w_word} > c_depth)
                        r_state <= ERR;
                     else
                        r_state <= DATA;
                  end
               end
               DATA: begin
                  if (w_word_ready) begin
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= r_word_idx[INST_MEM_WIDTH-1:0];
                     r_mem_wdata <= w_word;
                     r_word_idx  <= w_next_idx;
                     if (w_next_idx == r_len_words)
                        r_state <= DONE;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign inst_enable = r_inst_enable;
   assign load_busy   = (r_state == LEN) || (r_state == DATA);
   assign load_error  = (r_state == ERR);

endmodule
`default_nettype wire

// File: tb/tb_prog_loader_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_loader_ctrl
//  Purpose  : Self-checking bench for prog_loader_ctrl (stream-level model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_loader_ctrl;

   localparam int     W     = 2;
   localparam longint DEPTH = 64'd1 << W;

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic [7:0]    input_data = 8'd0;
   logic          input_valid = 1'b0;
   logic          input_start = 1'b0;
   logic          mem_we;
   logic [W-1:0]  mem_addr;
   logic [31:0]   mem_wdata;
   logic          inst_enable;
   logic          load_busy;
   logic          load_error;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   prog_loader_ctrl #(.INST_MEM_WIDTH(W)) dut (
      .CLK         (CLK),
      .reset       (reset),
      .input_data  (input_data),
      .input_valid (input_valid),
      .input_start (input_start),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .inst_enable (inst_enable),
      .load_busy   (load_busy),
      .load_error  (load_error)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: the list of bytes accepted since the last start decides everything.
   logic [7:0]   mb[$];
   bit           m_started = 0;
   bit           m_live = 0;
   int           done_age = 0;
   bit           e_we = 0;
   logic [W-1:0] e_addr = '0;
   logic [31:0]  e_wdata = 32'd0;

   function automatic longint m_len();
      logic [31:0] l;
      l = {mb[0], mb[1], mb[2], mb[3]};
      return longint'(l);
   endfunction
   function automatic bit m_error();
      return m_started && mb.size() >= 4 && m_len() > DEPTH;
   endfunction
   function automatic bit m_complete();
      return m_started && mb.size() >= 4 && m_len() <= DEPTH &&
             longint'((mb.size() - 4) / 4) >= m_len();
   endfunction
   function automatic bit m_busy();
      return m_started && !m_error() && !m_complete();
   endfunction

   task automatic model_step();
      bit was_complete;
      int n;
      was_complete = m_complete();
      e_we = 0;
      if (reset) begin
         m_started = 0; mb.delete(); done_age = 0;
         e_addr = '0; e_wdata = 32'd0; m_live = 1;
      end else if (input_start) begin
         m_started = 1; mb.delete(); done_age = 0;
      end else if (input_valid && m_busy()) begin
         mb.push_back(input_data);
         n = mb.size();
         if (n >= 8 && n % 4 == 0) begin
            e_we    = 1;
            e_addr  = W'((n - 8) / 4);
            e_wdata = {mb[n-4], mb[n-3], mb[n-2], mb[n-1]};
         end
      end else if (was_complete) begin
         done_age++;
      end
   endtask

   initial forever begin
      @(posedge CLK);
      model_step();
   end

   logic [W-1:0] got_a[$];
   logic [31:0]  got_d[$];

   initial forever begin
      @(negedge CLK);
      if (m_live) begin
         chk("mem_we", mem_we, e_we);
         chk("inst_enable", inst_enable, m_complete() && done_age >= 1);
         chk("load_busy", load_busy, m_busy());
         chk("load_error", load_error, m_error());
         if (e_we || !m_started) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wdata);
         end
      end
      if (mem_we) begin
         got_a.push_back(mem_addr);
         got_d.push_back(mem_wdata);
      end
   end

   task automatic drive(input bit v, input bit s, input logic [7:0] d);
      input_valid = v; input_start = s; input_data = d;
      @(negedge CLK);
      input_valid = 1'b0; input_start = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 8'($urandom));
   endtask
   task automatic send_byte(input logic [7:0] b, input int maxgap);
      idle(int'($urandom_range(0, maxgap)));
      drive(1'b1, 1'b0, b);
   endtask
   task automatic send_word(input logic [31:0] w, input int maxgap);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], maxgap);
   endtask
   task automatic do_start();
      drive(1'b0, 1'b1, 8'h00);
   endtask
   task automatic do_reset();
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
   endtask
   task automatic clear_log();
      got_a.delete(); got_d.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] w3[3];
   logic [W-1:0] ref_a[$];
   logic [31:0]  ref_d[$];

   initial begin
      repeat (2) @(negedge CLK);
      reset = 1'b0;
      chk("rst_we", mem_we, 0);
      chk("rst_enable", inst_enable, 0);
      chk("rst_busy", load_busy, 0);

      // Two-word load
      clear_log();
      do_start();
      send_word(32'd2, 0); send_word(32'hDEADBEEF, 0); send_word(32'h01020304, 0);
      idle(3);
      chk("t2w_count", got_a.size(), 2);
      if (got_a.size() == 2) begin
         chk("t2w_a0", got_a[0], 0); chk("t2w_d0", got_d[0], 32'hDEADBEEF);
         chk("t2w_a1", got_a[1], 1); chk("t2w_d1", got_d[1], 32'h01020304);
      end
      chk("t2w_enable", inst_enable, 1);

      // Zero-length load
      clear_log();
      do_start();
      send_word(32'd0, 0);
      idle(2);
      chk("tz_count", got_a.size(), 0);
      chk("tz_enable", inst_enable, 1);
      chk("tz_busy", load_busy, 0);

      // Overflow, then maximum length
      clear_log();
      do_start();
      send_word(32'd5, 0);
      idle(2);
      chk("tov_error", load_error, 1);
      chk("tov_enable", inst_enable, 0);
      send_word(32'hCAFEF00D, 0);
      idle(2);
      chk("tov_count", got_a.size(), 0);
      do_start();
      send_word(32'd4, 0);
      for (int i = 0; i < 4; i++) send_word(32'h1000 + i, 0);
      idle(3);
      chk("tmax_count", got_a.size(), 4);
      for (int i = 0; i < 4 && i < got_a.size(); i++) begin
         chk("tmax_addr", got_a[i], i);
         chk("tmax_data", got_d[i], 32'h1000 + i);
      end

      // Abort of a partial word by a start coincident with a byte
      clear_log();
      do_start();
      send_word(32'd1, 0);
      send_byte(8'hAA, 0); send_byte(8'hBB, 0);
      drive(1'b1, 1'b1, 8'hCC);
      send_word(32'd1, 0); send_word(32'h11223344, 0);
      idle(3);
      chk("tab_count", got_a.size(), 1);
      if (got_a.size() == 1) begin
         chk("tab_addr", got_a[0], 0); chk("tab_data", got_d[0], 32'h11223344);
      end

      // Reset mid-load
      clear_log();
      do_start();
      send_word(32'd2, 0);
      send_byte(8'h12, 0); send_byte(8'h34, 0);
      do_reset();
      chk("trs_we", mem_we, 0);   chk("trs_busy", load_busy, 0);
      chk("trs_addr", mem_addr, 0); chk("trs_data", mem_wdata, 0);
      send_word(32'h5678_9ABC, 0); send_word(32'h0000_0001, 0);
      idle(2);
      chk("trs_count", got_a.size(), 0);
      chk("trs_enable", inst_enable, 0);

      // Gapped stream versus back-to-back stream
      for (int i = 0; i < 3; i++) w3[i] = $urandom;
      clear_log();
      do_start();
      send_word(32'd3, 0);
      for (int i = 0; i < 3; i++) send_word(w3[i], 0);
      idle(3);
      ref_a = got_a; ref_d = got_d;
      chk("tgap_ref_count", ref_a.size(), 3);
      clear_log();
      do_start();
      send_word(32'd3, 20);
      for (int i = 0; i < 3; i++) send_word(w3[i], 20);
      idle(3);
      chk("tgap_count", got_a.size(), ref_a.size());
      for (int i = 0; i < got_a.size() && i < ref_a.size(); i++) begin
         chk("tgap_addr", got_a[i], ref_a[i]);
         chk("tgap_data", got_d[i], ref_d[i]);
      end

      // Random traffic against the model
      for (int it = 0; it < 40; it++) begin
         int n;
         int abort_at;
         int k;
         n = int'($urandom_range(0, 6));
         abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 12)) : -1;
         k = 0;
         do_start();
         send_word((n == 6) ? 32'h0100_0000 : 32'(n), 3);
         for (int b = 0; b < 4 * ((n > 4) ? 2 : n); b++) begin
            if (k == abort_at) begin
               if ($urandom_range(0, 1) == 1) drive(1'b1, 1'b1, 8'($urandom));
               else do_reset();
            end
            send_byte(8'($urandom), 3);
            k++;
         end
         idle(int'($urandom_range(1, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
